// File: rtl/kf76489_bus_interface.sv
// CPU-side write decoder for the KF76489 sound core: accepts CE/WE byte writes, decodes
// SN76489-style latch/data bytes and issues one-cycle register write strobes to the channels.
module kf76489_bus_interface #(
  parameter int unsigned WRITE_CYCLES = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       chip_enable_n,
  input  logic       write_enable_n,
  input  logic [7:0] data_bus,
  output logic       ready,
  output logic [7:0] internal_data_bus,
  output logic [2:0] write_frequency_h,
  output logic [2:0] write_frequency_l,
  output logic [3:0] write_attenuation,
  output logic       write_noise_control
);

  typedef enum logic [1:0] {StIdle, StBusy, StWaitRelease} state_e;

  localparam logic [7:0] BusyLoad = 8'(WRITE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [2:0] latched_q, latched_d;
  logic [7:0] idb_q, idb_d;
  logic [2:0] freq_h_q, freq_h_d;
  logic [2:0] freq_l_q, freq_l_d;
  logic [3:0] att_q, att_d;
  logic       noise_q, noise_d;
  logic       ready_q, ready_d;

  logic       write_req;
  logic [2:0] sel;
  logic [1:0] ch;

  assign write_req = !chip_enable_n && !write_enable_n;
  // Data bytes target whatever register the last latch byte selected.
  assign sel       = data_bus[7] ? data_bus[6:4] : latched_q;
  assign ch        = sel[2:1];

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    latched_d = latched_q;
    idb_d     = idb_q;
    freq_h_d  = 3'b000;
    freq_l_d  = 3'b000;
    att_d     = 4'b0000;
    noise_d   = 1'b0;
    ready_d   = ready_q;

    unique case (state_q)
      StIdle: begin
        ready_d = 1'b1;
        if (write_req) begin
          state_d = StBusy;
          count_d = BusyLoad;
          ready_d = 1'b0;
          if (data_bus[7]) begin
            latched_d = data_bus[6:4];
          end
          if (sel[0]) begin
            att_d = 4'b0001 << ch;
            idb_d = {data_bus[3:0], 4'b0000};
          end else if (ch == 2'd3) begin
            noise_d = 1'b1;
            idb_d   = {data_bus[3:0], 4'b0000};
          end else if (data_bus[7]) begin
            freq_h_d = 3'b001 << ch;
            idb_d    = {data_bus[3:0], 4'b0000};
          end else begin
            freq_l_d = 3'b001 << ch;
            idb_d    = {data_bus[5:0], 2'b00};
          end
        end
      end
      StBusy: begin
        ready_d = 1'b0;
        if (count_q == 8'd0) begin
          ready_d = 1'b1;
          // A write still held after the busy window must be released before the next accept.
          state_d = write_req ? StWaitRelease : StIdle;
        end else begin
          count_d = count_q - 8'd1;
        end
      end
      StWaitRelease: begin
        ready_d = 1'b1;
        if (!write_req) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= 8'd0;
      latched_q <= 3'b000;
      idb_q     <= 8'h00;
      freq_h_q  <= 3'b000;
      freq_l_q  <= 3'b000;
      att_q     <= 4'b0000;
      noise_q   <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      latched_q <= latched_d;
      idb_q     <= idb_d;
      freq_h_q  <= freq_h_d;
      freq_l_q  <= freq_l_d;
      att_q     <= att_d;
      noise_q   <= noise_d;
      ready_q   <= ready_d;
    end
  end

  assign ready               = ready_q;
  assign internal_data_bus   = idb_q;
  assign write_frequency_h   = freq_h_q;
  assign write_frequency_l   = freq_l_q;
  assign write_attenuation   = att_q;
  assign write_noise_control = noise_q;

endmodule
